// File: rtl/oled_request_arbiter.sv
`timescale 1ns/1ps
// oled_request_arbiter
//
// Front-end between the board push-buttons and the OLED interface core.
// Each of N_CH raw buttons is synchronised and debounced. A debounced press
// queues one request for that channel. Queued requests are issued to the core
// one at a time, in round-robin order, each with its own mode and background
// colour.
//
// Ports
//   i_CLK               single clock
//   i_RST               synchronous reset, active low
//   i_BTN               raw asynchronous buttons, active high
//   i_CH_MODE           per-channel mode, channel k at [k*MODE_W +: MODE_W]
//   i_CH_COLOR          per-channel colour, channel k at [k*COLOR_W +: COLOR_W]
//   i_READY             core idle flag
//   o_START             one-cycle start pulse to the core
//   o_MODE              mode of the granted request, held until the next grant
//   o_BACKGROUND_COLOR  colour of the granted request, held until the next grant
//   o_PENDING           queued request per channel
//   o_OVERRUN           sticky: a press arrived while its channel was pending
//   o_ACTIVE_CH         last granted channel
//   o_BUSY              a request is in flight
//   o_ERR               sticky: the core never acknowledged a start
module oled_request_arbiter #(
    parameter int N_CH            = 4,
    parameter int MODE_W          = 2,
    parameter int COLOR_W         = 8,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int ACK_TIMEOUT     = 16,
    parameter int CH_W            = $clog2(N_CH)
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic [N_CH-1:0]           i_BTN,
    input  logic [N_CH*MODE_W-1:0]    i_CH_MODE,
    input  logic [N_CH*COLOR_W-1:0]   i_CH_COLOR,
    input  logic                      i_READY,
    output logic                      o_START,
    output logic [MODE_W-1:0]         o_MODE,
    output logic [COLOR_W-1:0]        o_BACKGROUND_COLOR,
    output logic [N_CH-1:0]           o_PENDING,
    output logic [N_CH-1:0]           o_OVERRUN,
    output logic [CH_W-1:0]           o_ACTIVE_CH,
    output logic                      o_BUSY,
    output logic                      o_ERR
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    logic [N_CH-1:0]  sync_a, sync_b, db_state, db_prev, press;
    logic [DB_W-1:0]  db_cnt [N_CH];
    state_t           state, state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic             grant, timeout, grant_found;
    logic [CH_W-1:0]  grant_ch;
    logic [N_CH-1:0]  grant_mask;

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, then a counter that must see the
    // synchronised value differ from the debounced state for
    // DEBOUNCE_CYCLES consecutive cycles before the state follows it.
    // ------------------------------------------------------------------
    // NOTE: every flop here uses non-blocking assignment so that sync_b reads
    // the previous sync_a, not the value written earlier in this same block.
    // NOTE: the counter array is a small register file, not a RAM, so it is
    // reset along with everything else; a button held through reset then
    // debounces from a known zero state.
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            sync_a   <= '0;
            sync_b   <= '0;
            db_state <= '0;
            db_prev  <= '0;
            for (int k = 0; k < N_CH; k++) db_cnt[k] <= '0;
        end else begin
            sync_a  <= i_BTN;
            sync_b  <= sync_a;
            db_prev <= db_state;
            for (int k = 0; k < N_CH; k++) begin
                if (sync_b[k] == db_state[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_state[k] <= sync_b[k];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    assign press = db_state & ~db_prev;

    // ------------------------------------------------------------------
    // Round-robin search: first pending channel above the last grant.
    // ------------------------------------------------------------------
    // NOTE: each always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!grant_found && o_PENDING[(int'(o_ACTIVE_CH) + i) % N_CH]) begin
                grant_found = 1'b1;
                grant_ch    = CH_W'((int'(o_ACTIVE_CH) + i) % N_CH);
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: next state and strobes.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && i_READY) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!i_READY) begin
                    state_next = WAIT_DONE;
                end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (i_READY) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_mask = '0;
        if (grant) grant_mask[grant_ch] = 1'b1;
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            state              <= IDLE;
            o_START            <= 1'b0;
            tmo_cnt            <= '0;
            o_MODE             <= '0;
            o_BACKGROUND_COLOR <= '0;
            o_ACTIVE_CH        <= CH_W'(N_CH - 1);
            o_ERR              <= 1'b0;
        end else begin
            state   <= state_next;
            o_START <= (state_next == ISSUE);
            // Counts cycles spent in WAIT_BUSY; cleared in every other state.
            tmo_cnt <= (state == WAIT_BUSY) ? tmo_cnt + TMO_W'(1) : '0;
            if (grant) begin
                o_MODE             <= i_CH_MODE[grant_ch*MODE_W +: MODE_W];
                o_BACKGROUND_COLOR <= i_CH_COLOR[grant_ch*COLOR_W +: COLOR_W];
                o_ACTIVE_CH        <= grant_ch;
            end
            if (timeout) o_ERR <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending / overrun flags. A press that lands on the grant cycle of its
    // own channel is a fresh request (it will be issued again), so it keeps
    // the pending bit set and is not reported as an overrun.
    // ------------------------------------------------------------------
    always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
            o_PENDING <= '0;
            o_OVERRUN <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (press[k]) begin
                    if (o_PENDING[k] && !grant_mask[k]) o_OVERRUN[k] <= 1'b1;
                    o_PENDING[k] <= 1'b1;
                end else if (grant_mask[k]) begin
                    o_PENDING[k] <= 1'b0;
                end
            end
        end
    end

    assign o_BUSY = (state != IDLE);

endmodule

// File: tb/tb_oled_request_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for oled_request_arbiter: directed scenarios with
// literal expectations, then randomized buttons, channel data and core
// behaviour, all compared each cycle against a behavioural model.
module tb_oled_request_arbiter;

    localparam int N   = 4;
    localparam int MW  = 2;
    localparam int CW  = 8;
    localparam int D   = 20;
    localparam int AT  = 16;
    localparam int MBW = N * MW;
    localparam int CBW = N * CW;

    logic           clk;
    logic           rst = 1'b0;
    logic [N-1:0]   btn = '0;
    logic [MBW-1:0] ch_mode = '0;
    logic [CBW-1:0] ch_color = '0;
    logic           ready = 1'b1;
    logic           o_START, o_BUSY, o_ERR;
    logic [MW-1:0]  o_MODE;
    logic [CW-1:0]  o_BACKGROUND_COLOR;
    logic [N-1:0]   o_PENDING, o_OVERRUN;
    logic [1:0]     o_ACTIVE_CH;

    oled_request_arbiter #(
        .N_CH(N), .MODE_W(MW), .COLOR_W(CW), .DEBOUNCE_CYCLES(D), .ACK_TIMEOUT(AT)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_BTN(btn), .i_CH_MODE(ch_mode),
        .i_CH_COLOR(ch_color), .i_READY(ready), .o_START(o_START),
        .o_MODE(o_MODE), .o_BACKGROUND_COLOR(o_BACKGROUND_COLOR),
        .o_PENDING(o_PENDING), .o_OVERRUN(o_OVERRUN), .o_ACTIVE_CH(o_ACTIVE_CH),
        .o_BUSY(o_BUSY), .o_ERR(o_ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int start_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue order as one number: one nibble per start, channel+1.
    function automatic logic [31:0] enc_log();
        logic [31:0] v = 0;
        foreach (start_log[i]) v = (v << 4) | 32'(start_log[i] + 1);
        return v;
    endfunction

    // ---------------- core model ----------------
    bit force_low = 1'b0;   // bench holds ready low
    bit no_ack    = 1'b0;   // core ignores starts
    bit core_rand = 1'b0;   // random acknowledge latency
    int core_lat  = 10;
    int core_cnt  = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (o_START === 1'b1) begin
                if (core_rand)
                    core_cnt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
                else
                    core_cnt = no_ack ? 0 : core_lat;
            end else if (core_cnt > 0) begin
                core_cnt--;
            end
            ready = force_low ? 1'b0 : (core_cnt == 0);
        end
    end

    // ---------------- behavioural model ----------------
    // m_age: cycles since the grant (0 = nothing in flight, 1 = start cycle).
    logic [N-1:0]  m_s1, m_s2, m_db, m_rise, m_pend, m_ovr;
    int            m_run[N];
    int            m_last, m_age, m_gch, m_c;
    bit            m_acked, m_err, m_g;
    logic [MW-1:0] m_mode;
    logic [CW-1:0] m_color;

    always @(posedge clk) begin
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0;
            foreach (m_run[k]) m_run[k] = 0;
            m_pend = '0; m_ovr = '0; m_err = 1'b0;
            m_mode = '0; m_color = '0; m_last = N - 1;
            m_age = 0; m_acked = 1'b0;
        end else begin
            m_g = 1'b0;
            m_gch = 0;
            if (m_age == 0 && m_pend != 0 && ready) begin
                for (int i = 1; i <= N; i++) begin
                    m_c = (m_last + i) % N;
                    if (!m_g && m_pend[m_c]) begin
                        m_g = 1'b1;
                        m_gch = m_c;
                    end
                end
            end
            if (m_age == 0) begin
                if (m_g) begin
                    m_age   = 1;
                    m_last  = m_gch;
                    m_mode  = ch_mode[m_gch*MW +: MW];
                    m_color = ch_color[m_gch*CW +: CW];
                end
            end else if (m_age == 1) begin
                m_age = 2;
                m_acked = 1'b0;
            end else if (!m_acked) begin
                if (!ready) m_acked = 1'b1;
                else if (m_age - 1 == AT) begin m_err = 1'b1; m_age = 0; end
                else m_age++;
            end else if (ready) begin
                m_age = 0;
            end
            for (int k = 0; k < N; k++) begin
                if (m_rise[k]) begin
                    if (m_pend[k] && !(m_g && m_gch == k)) m_ovr[k] = 1'b1;
                    m_pend[k] = 1'b1;
                end else if (m_g && m_gch == k) begin
                    m_pend[k] = 1'b0;
                end
            end
            for (int k = 0; k < N; k++) begin
                m_rise[k] = 1'b0;
                if (m_s2[k] != m_db[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_db[k]   = m_s2[k];
                        m_run[k]  = 0;
                        m_rise[k] = m_s2[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("start",   32'(o_START),            32'(m_age == 1));
            check("busy",    32'(o_BUSY),             32'(m_age != 0));
            check("pending", 32'(o_PENDING),          32'(m_pend));
            check("overrun", 32'(o_OVERRUN),          32'(m_ovr));
            check("active",  32'(o_ACTIVE_CH),        32'(m_last));
            check("err",     32'(o_ERR),              32'(m_err));
            check("mode",    32'(o_MODE),             32'(m_mode));
            check("color",   32'(o_BACKGROUND_COLOR), 32'(m_color));
            if (o_START === 1'b1) start_log.push_back(int'(o_ACTIVE_CH));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        btn = '0;
        wait_neg(2);
        chk_en = 1'b1;
        rst = 1'b1;
        start_log.delete();
    endtask

    task automatic press_release(input logic [N-1:0] mask);
        btn = mask;
        wait_neg(30);
        btn = '0;
        wait_neg(30);
    endtask

    initial begin
        ch_mode  = MBW'($urandom);
        ch_color = CBW'($urandom);

        // 1: clean press on channel 1, core drops ready for 10 cycles
        do_reset();
        wait_neg(2);
        btn[1] = 1'b1;
        wait_neg(22);
        check("t1_pend_before", 32'(o_PENDING[1]), 32'd0);
        wait_neg(1);
        check("t1_pend_rise", 32'(o_PENDING[1]), 32'd1);
        wait_neg(1);
        check("t1_start",  32'(o_START), 32'd1);
        check("t1_mode",   32'(o_MODE), 32'(ch_mode[1*MW +: MW]));
        check("t1_color",  32'(o_BACKGROUND_COLOR), 32'(ch_color[1*CW +: CW]));
        check("t1_active", 32'(o_ACTIVE_CH), 32'd1);
        wait_neg(1);
        check("t1_start_width", 32'(o_START), 32'd0);
        wait_neg(15);
        btn = '0;
        wait_neg(40);
        check("t1_log", enc_log(), 32'h2);

        // 2: bouncing button never registers
        do_reset();
        for (int s = 0; s < 20; s++) begin
            btn[0] = ~btn[0];
            wait_neg(5);
        end
        btn[0] = 1'b0;
        wait_neg(40);
        check("t2_pending", 32'(o_PENDING), 32'd0);
        check("t2_log", enc_log(), 32'h0);

        // 3: round-robin order from reset, then after a grant on channel 2
        do_reset();
        force_low = 1'b1;
        press_release(4'b1101);
        check("t3_pend", 32'(o_PENDING), 32'hd);
        force_low = 1'b0;
        wait_neg(80);
        check("t3_order_a", enc_log(), 32'h134);
        press_release(4'b0100);
        wait_neg(10);
        check("t3_last2", 32'(o_ACTIVE_CH), 32'd2);
        force_low = 1'b1;
        start_log.delete();
        press_release(4'b1101);
        force_low = 1'b0;
        wait_neg(80);
        check("t3_order_b", enc_log(), 32'h413);

        // 4: second press while pending -> overrun, one start
        do_reset();
        force_low = 1'b1;
        press_release(4'b0100);
        press_release(4'b0100);
        check("t4_overrun", 32'(o_OVERRUN), 32'h4);
        check("t4_pend", 32'(o_PENDING), 32'h4);
        force_low = 1'b0;
        wait_neg(40);
        check("t4_log", enc_log(), 32'h3);

        // 5: press landing on the grant cycle of its channel
        do_reset();
        force_low = 1'b1;
        press_release(4'b0100);
        btn[2] = 1'b1;
        wait_neg(D + 2);
        force_low = 1'b0;
        wait_neg(1);
        check("t5_pend_kept", 32'(o_PENDING[2]), 32'd1);
        check("t5_start", 32'(o_START), 32'd1);
        check("t5_no_ovr", 32'(o_OVERRUN), 32'd0);
        wait_neg(30);
        btn = '0;
        wait_neg(40);
        check("t5_log", enc_log(), 32'h33);

        // 6: core never acknowledges -> error after ACK_TIMEOUT cycles
        do_reset();
        no_ack = 1'b1;
        wait_neg(2);
        btn[3] = 1'b1;
        wait_neg(24);
        check("t6_start", 32'(o_START), 32'd1);
        wait_neg(AT);
        check("t6_err_early", 32'(o_ERR), 32'd0);
        check("t6_busy", 32'(o_BUSY), 32'd1);
        wait_neg(1);
        check("t6_err", 32'(o_ERR), 32'd1);
        check("t6_idle", 32'(o_BUSY), 32'd0);
        btn = '0;
        no_ack = 1'b0;
        wait_neg(40);
        check("t6_dropped", 32'(o_PENDING), 32'd0);
        check("t6_log", enc_log(), 32'h4);

        // 7: reset in WAIT_DONE with two channels pending
        do_reset();
        wait_neg(2);
        btn[1] = 1'b1;
        wait_neg(24);
        check("t7_start", 32'(o_START), 32'd1);
        force_low = 1'b1;
        btn = 4'b1001;
        wait_neg(30);
        btn = '0;
        wait_neg(2);
        check("t7_pend", 32'(o_PENDING), 32'h9);
        check("t7_busy", 32'(o_BUSY), 32'd1);
        rst = 1'b0;
        wait_neg(1);
        check("t7_rst_outs", {o_START, o_BUSY, o_ERR, o_PENDING, o_OVERRUN, o_MODE, o_BACKGROUND_COLOR},
              32'd0);
        check("t7_rst_active", 32'(o_ACTIVE_CH), 32'd3);
        rst = 1'b1;
        force_low = 1'b0;
        start_log.delete();
        wait_neg(60);
        check("t7_log", enc_log(), 32'h0);

        // 8: randomized traffic against the model
        begin
            int hold[N];
            do_reset();
            core_rand = 1'b1;
            foreach (hold[k]) hold[k] = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                for (int k = 0; k < N; k++) begin
                    if (hold[k] == 0) begin
                        btn[k]  = 1'($urandom_range(0, 1));
                        hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                                              : int'($urandom_range(15, 45));
                    end else begin
                        hold[k]--;
                    end
                end
                if ($urandom_range(0, 15) == 0) ch_mode  = MBW'($urandom);
                if ($urandom_range(0, 15) == 0) ch_color = CBW'($urandom);
                if ($urandom_range(0, 63) == 0) force_low = ~force_low;
                if ($urandom_range(0, 1499) == 0) begin
                    rst = 1'b0;
                    wait_neg(2);
                    rst = 1'b1;
                end
                wait_neg(1);
            end
            btn = '0;
            force_low = 1'b0;
            core_rand = 1'b0;
            wait_neg(100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_request_arbiter.md
# oled_request_arbiter

Multi-channel front-end between the board's push-buttons and the OLED interface core. It generalises a single button-tick start path to N_CH debounced request channels, each carrying its own mode and background colour. It queues one pending request per channel and issues them to the OLED interface one at a time, using round-robin arbitration. Each request is handed off with a start pulse and then tracked through the core's ready/busy handshake. The block sits in the synth top between the raw buttons/switches and the OLED interface's i_START / i_MODE / i_BACKGROUND_COLOR inputs.

## Interface
- N_CH, 4, number of request channels (buttons); 2..8
- MODE_W, 2, width of a mode code
- COLOR_W, 8, width of a background colour
- DEBOUNCE_CYCLES, 20, cycles a synchronised input must stay constant before the debounced state follows it; ≥2
- ACK_TIMEOUT, 16, maximum cycles after o_START for i_READY to fall
- CH_W, $clog2(N_CH), channel index width (derived)

Ports:
- i_CLK  in  1  single clock for all logic
- i_RST  in  1  synchronous, active-low reset
- i_BTN  in  N_CH  raw asynchronous buttons, active-high
- i_CH_MODE  in  N_CH*MODE_W  per-channel mode; channel k occupies [k*MODE_W +: MODE_W]
- i_CH_COLOR  in  N_CH*COLOR_W  per-channel background colour; channel k occupies [k*COLOR_W +: COLOR_W]
- i_READY  in  1  OLED interface ready (high = idle)
- o_START  out  1  one-cycle start pulse to the OLED interface
- o_MODE  out  MODE_W  mode of the granted request; held stable until the next grant
- o_BACKGROUND_COLOR  out  COLOR_W  colour of the granted request; held stable until the next grant
- o_PENDING  out  N_CH  pending-request flags
- o_OVERRUN  out  N_CH  sticky: a press arrived while that channel was already pending
- o_ACTIVE_CH  out  CH_W  last granted channel
- o_BUSY  out  1  FSM is not in IDLE
- o_ERR  out  1  sticky: an acknowledge timeout occurred

## Operation
- Input path, per channel:
  - 2-flop synchroniser.
  - Counter cleared whenever the synchronised value equals the debounced state, incremented otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the value is still different, the debounced state takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Pending logic:
  - A debounced rising edge sets o_PENDING[k] on the following cycle.
  - If o_PENDING[k] is already set at that point, o_OVERRUN[k] is set instead; the request is not counted twice.
  - If a set and a grant-clear for the same channel occur in the same cycle, the set wins and the bit stays 1.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if |o_PENDING and i_READY, grant the first pending channel searching upward from o_ACTIVE_CH+1 (mod N_CH). Latch that channel's mode and colour into o_MODE / o_BACKGROUND_COLOR, set o_ACTIVE_CH, clear its pending bit, go to ISSUE.
  - ISSUE: o_START=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: if i_READY=0, go to WAIT_DONE. If ACK_TIMEOUT cycles elapse with i_READY still 1, set o_ERR and go to IDLE; the request is dropped, not re-queued.
  - WAIT_DONE: when i_READY=1, go to IDLE.
- Mode and colour are sampled only at grant. Later changes on i_CH_MODE / i_CH_COLOR do not affect a request in flight.
- Reset (i_RST=0 at a clock edge), including mid-transfer:
  - FSM returns to IDLE.
  - o_START=0, o_PENDING=0, o_OVERRUN=0, o_ERR=0, o_BUSY=0.
  - o_MODE=0, o_BACKGROUND_COLOR=0.
  - o_ACTIVE_CH=N_CH-1, so that channel 0 is searched first.
  - Debounced states, counters and synchroniser flops are cleared to 0.
  - Any button held through reset produces a press DEBOUNCE_CYCLES+2 cycles after reset is released.

## Timing
- Button to pending: the raw edge is in the synchroniser for 2 cycles. The debounced state flips DEBOUNCE_CYCLES cycles after the synchronised value first differs. o_PENDING rises 1 cycle later, for DEBOUNCE_CYCLES+3 cycles in total.
- Pending to start: with the FSM in IDLE and i_READY=1, grant happens in the cycle o_PENDING is seen high. o_START is high the next cycle.
- o_MODE and o_BACKGROUND_COLOR are valid in the same cycle as o_START and remain valid until the next grant.
- Minimum spacing between two o_START pulses is 4 cycles (ISSUE, WAIT_BUSY, WAIT_DONE, IDLE), assuming the core drops and restores i_READY in one cycle each.
- o_BUSY is combinational from the state register: high in ISSUE, WAIT_BUSY and WAIT_DONE.
- All other outputs are registered.

## Test plan
- Reset, then a clean press on btn 1 held 40 cycles (DEBOUNCE_CYCLES=20), i_READY=1 with a core model that drops ready 1 cycle after start for 10 cycles -> o_PENDING[1] rises at cycle 23. o_START is one cycle wide with o_MODE = mode1 and o_BACKGROUND_COLOR = colour1. o_ACTIVE_CH=1.
- Bounce: btn 0 toggles every 5 cycles for 100 cycles, then held low -> no pending bit, no o_START.
- Presses on channels 0, 2 and 3 while i_READY=0, then i_READY=1 -> starts issued in order 0, 2, 3. Repeat the test with the last grant = 2 -> order 3, 0, 2.
- Second press on channel 2 while o_PENDING[2]=1 -> o_OVERRUN[2]=1 and only one start is issued for channel 2. Separately, a press landing on the grant cycle of channel 2 -> o_PENDING[2] stays 1 and a second start is issued.
- Core never drops i_READY after o_START -> o_ERR=1 exactly ACK_TIMEOUT cycles after WAIT_BUSY is entered, and the FSM returns to IDLE.
- i_RST=0 during WAIT_DONE with two channels pending -> the next cycle shows every output at its reset value. With no further presses, no start is issued after reset is released.
